// File: rtl/screen_rx.sv
//-----------------------------------------------------------------------------
// screen_rx -- 8N1 UART receiver driven by a 16x oversampling enable.
//
// The serial line is brought into the clk domain through a two-flop
// synchronizer (rx_s).  A falling edge on an idle line starts a frame.  The
// start bit is confirmed at its centre.  The eight data bits (LSB first) and
// the stop bit are then sampled one bit period apart.  A good stop bit
// publishes the byte with a one-clk data_valid pulse.  A bad stop bit gives a
// one-clk frame_err pulse and leaves data_out untouched.  The receiver goes
// back to IDLE at the centre of the stop bit, so a start bit that follows
// with no idle gap is still caught.
//
// Parameters
//   OVERSAMPLE   baud_tick16 pulses per bit period (only 16 is supported)
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   baud_tick16  one-clk enable pulse at 16x the baud rate
//   uart_rx      asynchronous serial input, idle high
//   data_out     last correctly received byte
//   data_valid   one-clk pulse when data_out has just been updated
//   frame_err    one-clk pulse when a stop bit is sampled low
//   busy         high while a frame is in progress (registered)
//
// Build option
//   SCREEN_RX_MAJORITY_EN  when defined, each sample is the 2-of-3 majority
//                          of rx_s on the three ticks that end at the sample
//                          point.  When undefined, each sample is rx_s on the
//                          sample-point tick only.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module screen_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick16,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int DATA_W = 8;

    // The start bit is checked half a bit after the edge.  Every later
    // sample is taken one full bit period after the previous one.
    localparam logic [3:0] CNT_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;
    logic [2:0]          idx;
    logic [2:0]          idx_nxt;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_nxt;

    logic                rx_meta_p0;
    logic                rx_s;
    logic                rx_prev;
    logic                fall;
    logic                samp;
    logic                stop_hit;
    logic                dv_nxt;
    logic                fe_nxt;

    assign fall = rx_prev & ~rx_s;

`ifdef SCREEN_RX_MAJORITY_EN
    // rx_s as it was on the two ticks just before the current one.
    logic [1:0] hist;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= 2'b11;
        end else if (baud_tick16) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign samp = maj3(hist[1], hist[0], rx_s);
`else
    assign samp = rx_s;
`endif

    //-------------------------------------------------------------------------
    // State register, synchronizer and registered outputs
    //-------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= IDLE;
            cnt        <= 4'd0;
            idx        <= 3'd0;
            shreg      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta_p0 <= uart_rx;
            rx_s       <= rx_meta_p0;
            rx_prev    <= rx_s;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            shreg      <= shreg_nxt;
            data_valid <= dv_nxt;
            frame_err  <= fe_nxt;
            // busy follows the next state so that it drops together with
            // the data_valid / frame_err pulse.
            busy       <= (state_nxt != IDLE);
            if (dv_nxt) begin
                data_out <= shreg;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Next-state logic
    //-------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;

        case (state)
            IDLE: begin
                // The edge is taken on any clk, tick or not.
                if (fall) begin
                    state_nxt = START;
                    cnt_nxt   = 4'd0;
                end
            end

            START: begin
                if (baud_tick16) begin
                    if (cnt == CNT_MID) begin
                        cnt_nxt   = 4'd0;
                        idx_nxt   = 3'd0;
                        // A start bit that is high again at its centre was a glitch.
                        state_nxt = samp ? IDLE : DATA;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (baud_tick16) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        shreg_nxt[idx] = samp;
                        idx_nxt        = idx + 3'd1;
                        if (idx == 3'd7) begin
                            state_nxt = STOP;
                            cnt_nxt   = 4'd0;
                        end
                    end
                end
            end

            STOP: begin
                if (baud_tick16) begin
                    cnt_nxt = cnt + 4'd1;
                    // Leave at mid-stop-bit so a back-to-back start edge is seen.
                    if (cnt == CNT_LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    //-------------------------------------------------------------------------
    // Output decode: stop-bit verdict, registered on the next edge
    //-------------------------------------------------------------------------
    always_comb begin
        stop_hit = (state == STOP) && baud_tick16 && (cnt == CNT_LAST);
        dv_nxt   = stop_hit & samp;
        fe_nxt   = stop_hit & ~samp;
    end

endmodule

// File: tb/tb_screen_rx.sv
`timescale 1ns/1ps

module tb_screen_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick16;
    logic       uart_rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    always #5 clk = ~clk;

    screen_rx #(.OVERSAMPLE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick16 (baud_tick16),
        .uart_rx     (uart_rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Line waveform for one segment, one entry per 16x tick.
    // seg[t] is the line level seen by tick t of the segment.
    // ------------------------------------------------------------------
    localparam int SEG_MAX = 8192;
    logic       seg      [SEG_MAX];
    logic       busy_exp [SEG_MAX];
    int         seg_n;

    // Expected pulses: tick index, kind (1 = data_valid, 0 = frame_err), data_out.
    int         exp_t    [$];
    logic       exp_kind [$];
    logic [7:0] exp_dout [$];

    logic [7:0] model_dout;
    logic       model_busy_end;
    logic       line_prev;
    int         cur_t;
    bit         stall_en;

    task automatic seg_clear();
        seg_n = 0;
    endtask

    task automatic seg_put(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            seg[seg_n] = v;
            seg_n++;
        end
    endtask

    task automatic seg_frame(input logic [7:0] b, input logic stop_v);
        seg_put(1'b0, 16);
        for (int i = 0; i < 8; i++) seg_put(b[i], 16);
        seg_put(stop_v, 16);
    endtask

    // Value the receiver decides on for a sample taken at tick t.
    function automatic logic samp_at(input int t);
`ifdef SCREEN_RX_MAJORITY_EN
        int ones;
        ones = int'(seg[t-2]) + int'(seg[t-1]) + int'(seg[t]);
        return (ones >= 2);
`else
        return seg[t];
`endif
    endfunction

    task automatic busy_fill(input int a, input int b);
        for (int i = a; i <= b; i++) busy_exp[i] = 1'b1;
    endtask

    // Frame decoder over the tick array.  The start bit is checked at tick
    // j0+7, data bit i at j0+23+16*i, and the stop bit at j0+151.
    task automatic model_segment(input logic prev_init);
        int         t;
        int         j0;
        int         last;
        logic       prev;
        logic       stop_ok;
        logic [7:0] b;
        for (int i = 0; i < seg_n; i++) busy_exp[i] = 1'b0;
        model_busy_end = 1'b0;
        t    = 0;
        prev = prev_init;
        while (t < seg_n) begin
            if (prev && !seg[t]) begin
                j0 = t;
                if (j0 + 7 >= seg_n) begin
                    busy_fill(j0, seg_n - 1);
                    model_busy_end = 1'b1;
                    t = seg_n;
                end else if (samp_at(j0 + 7)) begin
                    busy_fill(j0, j0 + 7);
                    prev = seg[j0 + 7];
                    t    = j0 + 8;
                end else begin
                    last = j0 + 151;
                    if (last >= seg_n) begin
                        busy_fill(j0, seg_n - 1);
                        model_busy_end = 1'b1;
                        t = seg_n;
                    end else begin
                        busy_fill(j0, last);
                        for (int i = 0; i < 8; i++) b[i] = samp_at(j0 + 23 + 16 * i);
                        stop_ok = samp_at(last);
                        if (stop_ok) model_dout = b;
                        exp_t.push_back(last);
                        exp_kind.push_back(stop_ok);
                        exp_dout.push_back(model_dout);
                        prev = seg[last];
                        t    = last + 1;
                    end
                end
            end else begin
                prev = seg[t];
                t++;
            end
        end
    endtask

    // One tick period of 4+ clks: the line changes right after the previous
    // tick edge, and the tick pulse is high in the last clk.
    task automatic tick_step(input logic v, input int t);
        uart_rx = v;
        repeat (3) @(posedge clk);
        if (stall_en && ($urandom_range(0, 47) == 0)) repeat (30) @(posedge clk);
        #1;
        check("busy", 32'(busy), 32'(busy_exp[t]));
        baud_tick16 = 1'b1;
        @(posedge clk);
        #1;
        baud_tick16 = 1'b0;
        cur_t = t + 1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_segment(input bit rst_after);
        model_segment(line_prev);
        for (int t = 0; t < seg_n; t++) tick_step(seg[t], t);
        if (rst_after) begin
            pulse_rst();
            check("evq_drained", 32'(exp_t.size()), 32'd0);
            exp_t.delete();
            exp_kind.delete();
            exp_dout.delete();
            model_dout = 8'h00;
            line_prev  = 1'b1;
            check("rst_dout", 32'(data_out), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
        end else begin
            line_prev = seg[seg_n - 1];
            check("evq_drained", 32'(exp_t.size()), 32'd0);
            check("seg_dout", 32'(data_out), 32'(model_dout));
            check("seg_busy", 32'(busy), 32'(model_busy_end));
        end
    endtask

    // ------------------------------------------------------------------
    // Pulse monitor
    // ------------------------------------------------------------------
    logic       last_pulse = 1'b0;
    int         n_dv = 0;
    int         n_fe = 0;
    logic [7:0] dv_hist [$];
    int         m_t;
    logic       m_kind;
    logic [7:0] m_dout;

    always @(negedge clk) begin
        if (last_pulse) check("pulse_1clk", 32'({data_valid, frame_err}), 32'd0);
        if (data_valid || frame_err) begin
            check("dv_fe_excl", 32'(data_valid & frame_err), 32'd0);
            check("busy_at_pulse", 32'(busy), 32'd0);
            if (data_valid) begin
                n_dv++;
                dv_hist.push_back(data_out);
            end
            if (frame_err) n_fe++;
            if (exp_t.size() == 0) begin
                check("unexpected_pulse", 32'({data_valid, frame_err}), 32'd0);
            end else begin
                m_t    = exp_t.pop_front();
                m_kind = exp_kind.pop_front();
                m_dout = exp_dout.pop_front();
                check("pulse_tick", 32'(cur_t - 1), 32'(m_t));
                check("pulse_kind", 32'(data_valid), 32'(m_kind));
                check("pulse_dout", 32'(data_out), 32'(m_dout));
            end
        end
        last_pulse = data_valid | frame_err;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int d0;
    int f0;
    int nfr;

    initial begin
        rst         = 1'b1;
        baud_tick16 = 1'b0;
        uart_rx     = 1'b1;
        stall_en    = 1'b0;
        line_prev   = 1'b1;
        model_dout  = 8'h00;
        cur_t       = 0;
        seg_n       = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", 32'(data_out), 32'd0);
        check("reset_dv", 32'(data_valid), 32'd0);
        check("reset_fe", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Single byte 0x55
        d0 = n_dv; f0 = n_fe;
        seg_clear(); seg_put(1'b1, 4); seg_frame(8'h55, 1'b1); seg_put(1'b1, 8);
        run_segment(1'b0);
        check("b55_dv_count", 32'(n_dv - d0), 32'd1);
        check("b55_fe_count", 32'(n_fe - f0), 32'd0);
        check("b55_dout", 32'(data_out), 32'h55);

        // 0xA3 then 0x3C with no idle gap
        d0 = n_dv;
        seg_clear(); seg_put(1'b1, 4); seg_frame(8'hA3, 1'b1); seg_frame(8'h3C, 1'b1); seg_put(1'b1, 8);
        run_segment(1'b0);
        check("b2b_dv_count", 32'(n_dv - d0), 32'd2);
        check("b2b_first", 32'(dv_hist[dv_hist.size() - 2]), 32'hA3);
        check("b2b_dout", 32'(data_out), 32'h3C);

        // 4-tick low glitch on an idle line
        d0 = n_dv; f0 = n_fe;
        seg_clear(); seg_put(1'b1, 8); seg_put(1'b0, 4); seg_put(1'b1, 24);
        run_segment(1'b0);
        check("glitch_dv_count", 32'(n_dv - d0), 32'd0);
        check("glitch_fe_count", 32'(n_fe - f0), 32'd0);
        check("glitch_dout", 32'(data_out), 32'h3C);

        // 0x81 with a low stop bit, then the line held low (break)
        d0 = n_dv; f0 = n_fe;
        seg_clear(); seg_put(1'b1, 4); seg_frame(8'h81, 1'b0); seg_put(1'b0, 200); seg_put(1'b1, 8);
        run_segment(1'b0);
        check("break_fe_count", 32'(n_fe - f0), 32'd1);
        check("break_dv_count", 32'(n_dv - d0), 32'd0);
        check("break_dout", 32'(data_out), 32'h3C);

        // Reset in the middle of data bit 3 of 0xFF, then 0x12
        d0 = n_dv; f0 = n_fe;
        seg_clear(); seg_put(1'b1, 4); seg_frame(8'hFF, 1'b1);
        seg_n = 4 + 16 + 3 * 16 + 8;
        run_segment(1'b1);
        seg_clear(); seg_put(1'b1, 4); seg_frame(8'h12, 1'b1); seg_put(1'b1, 8);
        run_segment(1'b0);
        check("rst_dv_count", 32'(n_dv - d0), 32'd1);
        check("rst_fe_count", 32'(n_fe - f0), 32'd0);
        check("rst_then_dout", 32'(data_out), 32'h12);

        // 0x00 with a one-tick high spike on the last tick of the bit-2 window
        seg_clear(); seg_put(1'b1, 4); seg_frame(8'h00, 1'b1);
        seg[4 + 16 + 2 * 16 + 7] = 1'b1;
        seg_put(1'b1, 8);
        run_segment(1'b0);
`ifdef SCREEN_RX_MAJORITY_EN
        check("spike_dout", 32'(data_out), 32'h00);
`else
        check("spike_dout", 32'(data_out), 32'h04);
`endif

        // Randomized well-formed traffic with glitches, bad stop bits and tick stalls
        stall_en = 1'b1;
        for (int s = 0; s < 24; s++) begin
            seg_clear();
            seg_put(1'b1, int'($urandom_range(2, 8)));
            nfr = int'($urandom_range(1, 3));
            for (int f = 0; f < nfr; f++) begin
                logic stop_v;
                if ($urandom_range(0, 4) == 0) begin
                    seg_put(1'b0, int'($urandom_range(1, 4)));
                    seg_put(1'b1, int'($urandom_range(8, 20)));
                end
                stop_v = ($urandom_range(0, 5) != 0);
                seg_frame(8'($urandom), stop_v);
                if (!stop_v) seg_put(1'b1, int'($urandom_range(1, 12)));
                else         seg_put(1'b1, int'($urandom_range(0, 12)));
            end
            seg_put(1'b1, 10);
            run_segment(1'b0);
        end
        stall_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_rx.md
SCREEN_RX -- requirements
Module: screen_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning baud_tick16 pulses per bit period; only 16 is supported.
REQ-002 SHALL have port clk input 1: system clock, 100 MHz, all logic on its rising edge.
REQ-003 SHALL have port rst input 1: reset, synchronous, active-high.
REQ-004 SHALL have port baud_tick16 input 1: one-clk-wide enable pulse at 16x the baud rate.
REQ-005 SHALL have port uart_rx input 1: asynchronous serial line, idle high.
REQ-006 SHALL have port data_out output 8: last correctly received byte.
REQ-007 SHALL have port data_valid output 1: one-clk pulse when data_out has just been updated.
REQ-008 SHALL have port frame_err output 1: one-clk pulse on a stop-bit error.
REQ-009 SHALL have port busy output 1: high while a frame is in progress.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP; busy = (state != IDLE), registered.
REQ-012 IDLE: SHALL detect a falling edge (rx_s previous 1, current 0) on any clk, whether or not baud_tick16 is high, then go to START with tick counter = 0.
REQ-013 tick counter (4-bit) SHALL increment only on clk cycles with baud_tick16 = 1, and wraps 15 -> 0.
REQ-014 START: on the tick where counter == 7, SHALL sample; sample 0 -> DATA, counter = 0, bit index = 0; sample 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 DATA: on each tick where counter == 15, SHALL sample into bit[index], LSB first; after index 7 -> STOP, counter = 0.
REQ-016 STOP: on the tick where counter == 15, SHALL sample; 1 -> data_out = shift register, data_valid pulse; 0 -> frame_err pulse, data_out unchanged.
REQ-017 STOP SHALL return to IDLE on the same sample cycle (mid-stop-bit), so a start edge arriving 8 ticks later is captured.
REQ-018 data_valid/frame_err SHALL assert on the clk after the stop sample tick, for exactly one clk; they are never high together.
REQ-019 Line held low after a frame error (break) SHALL produce no further frames until rx_s returns high and falls again.
REQ-020 baud_tick16 stuck low SHALL freeze the FSM in its current state, with no timeout.

Reset
REQ-021 rst SHALL force state IDLE, counter 0, bit index 0, shift register 0x00, data_out 0x00, data_valid 0, frame_err 0, busy 0, synchronizer flops 1.
REQ-022 rst asserted mid-frame SHALL discard the partial byte without a pulse; rst has priority over all other events in the same clk.

Configuration
REQ-023 Macro SCREEN_RX_MAJORITY_EN defined: each sample SHALL be the 2-of-3 majority of rx_s captured on the three ticks ending at the sample point (counter 5,6,7 for START; 13,14,15 for DATA/STOP).
REQ-024 Macro SCREEN_RX_MAJORITY_EN undefined: each sample SHALL be rx_s on the single sample-point tick; the majority registers SHALL be absent.

Verification
REQ-025 Send frame for 0x55 with a correct stop bit -> data_out = 0x55, one data_valid pulse, busy falls with it, frame_err stays 0.
REQ-026 Send 0xA3 immediately followed by 0x3C with no idle gap -> two data_valid pulses, data_out 0xA3 then 0x3C.
REQ-027 Send a 4-tick low glitch on an idle line -> FSM returns to IDLE at the tick where counter == 7; no pulses; data_out unchanged.
REQ-028 Send 0x81 with the stop bit driven 0 -> one frame_err pulse; data_out keeps its prior value; no new frame while the line stays low.
REQ-029 Assert rst for 1 clk during data bit 3 of 0xFF, then send 0x12 -> no output for 0xFF, data_out = 0x12 with one data_valid pulse.
REQ-030 With SCREEN_RX_MAJORITY_EN: send 0x00 with a 1-tick high spike at counter 15 of bit 2 -> data_out = 0x00; without the macro -> data_out = 0x04.
